// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request after last_grant, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    // Scan from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        int idx;
        idx    = 0;
        any    = |req;
        winner = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (req[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready requesters,
// with bursts capped at MAX_BURST beats and a registered write strobe/data toward the fifo.
import fifo_arb_pkg::*;

module fifo_rr_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = id_w(NUM_REQ),
    localparam int CNT_W    = cnt_w(MAX_BURST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write_enable,
    output logic [WIDTH-1:0]         fifo_data_in,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    arb_state_t       state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  winner;
    logic [CNT_W-1:0] beat_cnt;
    logic [WIDTH-1:0] owner_data;
    logic             any_req;
    logic             xfer;
    logic             last_beat;
    logic             rel;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .ID_W       (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (any_req),
        .winner     (winner)
    );

    assign busy       = (state == BURST);
    assign grant_id   = owner;
    assign owner_data = req_data[int'(owner)*WIDTH +: WIDTH];

    always_comb begin
        req_ready        = '0;
        req_ready[owner] = busy & !fifo_full;
    end

    assign xfer      = busy & req_valid[owner] & !fifo_full;
    assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
    // A full fifo freezes the grant: neither a transfer nor an idle release can happen.
    assign rel       = busy & ((xfer & (req_last[owner] | last_beat)) |
                               (!req_valid[owner] & !fifo_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            owner             <= '0;
            last_grant        <= ID_W'(NUM_REQ - 1);
            beat_cnt          <= '0;
            fifo_write_enable <= 1'b0;
            fifo_data_in      <= '0;
        end else begin
            fifo_write_enable <= xfer;
            if (xfer) fifo_data_in <= owner_data;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) beat_cnt <= beat_cnt + 1'b1;
                    if (rel) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
